// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty meter: FSM encodings, default counter
// width and the sizing helper for the edge-age counter.
package pwm_pkg;

    localparam int PWM_CNT_W_DEFAULT = 20;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } meas_state_e;

    // Smallest width that can hold the value TIMEOUT itself.
    function automatic int age_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, plus a registered copy of
// the synchronized level that yields single-cycle rise/fall strobes.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_prev_q;
    logic                   level_prev_d;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], async_in};
        level_prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            level_prev_q <= level_prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_prev_q;
    assign fall  = ~level & level_prev_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and rise-to-rise period of an external PWM line in sclk
// cycles, one result per period, and flags a line that has stopped toggling.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W_DEFAULT,
    parameter int TIMEOUT     = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             pwm_in,
    output logic             level,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam int               AGE_W     = age_width(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic rise;
    logic fall;
    logic edge_seen;

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q, valid_d;
    logic             stuck_hi_q, stuck_hi_d;
    logic             stuck_lo_q, stuck_lo_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .async_in (pwm_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    assign edge_seen = rise | fall;

    // A rise always counts as cycle 1 of the new period, both when arming
    // from IDLE and when closing a period in MEAS_LOW.
    always_comb begin
        state_d      = state_q;
        high_d       = high_q;
        period_d     = period_q;
        age_d        = age_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        valid_d      = 1'b0;
        stuck_hi_d   = stuck_hi_q;
        stuck_lo_d   = stuck_lo_q;

        if (edge_seen) begin
            age_d = '0;
        end else if (age_q != AGE_LIMIT) begin
            age_d = age_q + AGE_W'(1);
        end

        case (state_q)
            IDLE: begin
                high_d   = '0;
                period_d = '0;
                if (rise) begin
                    state_d  = MEAS_HIGH;
                    high_d   = CNT_ONE;
                    period_d = CNT_ONE;
                end
            end
            MEAS_HIGH: begin
                period_d = sat_inc(period_q);
                if (fall) begin
                    state_d = MEAS_LOW;
                end else begin
                    high_d = sat_inc(high_q);
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    high_cnt_d   = high_q;
                    period_cnt_d = period_q;
                    valid_d      = 1'b1;
                    high_d       = CNT_ONE;
                    period_d     = CNT_ONE;
                    state_d      = MEAS_HIGH;
                end else begin
                    period_d = sat_inc(period_q);
                end
            end
            default: begin
                state_d  = IDLE;
                high_d   = '0;
                period_d = '0;
            end
        endcase

        // An edge in the timeout cycle wins, so the timeout path only runs without one.
        if (edge_seen) begin
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end else if (age_d == AGE_LIMIT) begin
            if (level) begin
                stuck_hi_d = 1'b1;
            end else begin
                stuck_lo_d = 1'b1;
            end
            state_d  = IDLE;
            high_d   = '0;
            period_d = '0;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= IDLE;
            high_q       <= '0;
            period_q     <= '0;
            age_q        <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            stuck_hi_q   <= 1'b0;
            stuck_lo_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_q       <= high_d;
            period_q     <= period_d;
            age_q        <= age_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            valid_q      <= valid_d;
            stuck_hi_q   <= stuck_hi_d;
            stuck_lo_q   <= stuck_lo_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign meas_valid = valid_q;
    assign stuck_hi   = stuck_hi_q;
    assign stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: two instances (wide counters, and a narrow one for
// saturation), stimulus as runs of high/low cycles, results predicted from run lengths.
module tb_pwm_duty_meter;

    localparam int CNT_W_A   = 20;
    localparam int TIMEOUT_A = 200;
    localparam int CNT_W_B   = 6;
    localparam int TIMEOUT_B = 63;
    localparam int MAX_A     = (1 << CNT_W_A) - 1;
    localparam int MAX_B     = (1 << CNT_W_B) - 1;
    // Cycles from driving pwm_in at a negedge to seeing the registered response.
    localparam int LAT       = 3;

    logic               sclk    = 1'b0;
    logic               s_rst_n = 1'b1;
    logic               pwm_a   = 1'b0;
    logic               pwm_b   = 1'b0;
    logic               level_a, valid_a, stuck_hi_a, stuck_lo_a;
    logic               level_b, valid_b, stuck_hi_b, stuck_lo_b;
    logic [CNT_W_A-1:0] high_a, period_a;
    logic [CNT_W_B-1:0] high_b, period_b;

    typedef struct {
        int cyc;
        int hi;
        int per;
    } ev_t;

    ev_t evq_a[$];
    ev_t evq_b[$];
    ev_t exp_q[$];
    int  run_h[$];
    int  run_l[$];
    int  rise_cyc[$];
    int  cyc       = 0;
    int  last_fall = 0;
    int  checks    = 0;
    int  failures  = 0;

    pwm_duty_meter #(.CNT_W(CNT_W_A), .TIMEOUT(TIMEOUT_A), .SYNC_STAGES(2)) u_dut_a (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .pwm_in     (pwm_a),
        .level      (level_a),
        .high_cnt   (high_a),
        .period_cnt (period_a),
        .meas_valid (valid_a),
        .stuck_hi   (stuck_hi_a),
        .stuck_lo   (stuck_lo_a)
    );

    pwm_duty_meter #(.CNT_W(CNT_W_B), .TIMEOUT(TIMEOUT_B), .SYNC_STAGES(2)) u_dut_b (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .pwm_in     (pwm_b),
        .level      (level_b),
        .high_cnt   (high_b),
        .period_cnt (period_b),
        .meas_valid (valid_b),
        .stuck_hi   (stuck_hi_b),
        .stuck_lo   (stuck_lo_b)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    always @(negedge sclk) begin
        if (valid_a) evq_a.push_back('{cyc, int'(high_a), int'(period_a)});
        if (valid_b) evq_b.push_back('{cyc, int'(high_b), int'(period_b)});
    end

    task automatic set_pwm(input bit sel, input logic v);
        if (sel) pwm_b = v;
        else     pwm_a = v;
    endtask

    task automatic do_reset();
        @(negedge sclk);
        s_rst_n = 1'b0;
        pwm_a   = 1'b0;
        pwm_b   = 1'b0;
        repeat (3) @(negedge sclk);
        s_rst_n = 1'b1;
        evq_a.delete();
        evq_b.delete();
        rise_cyc.delete();
        run_h.delete();
        run_l.delete();
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 20000) begin
            @(negedge sclk);
            guard++;
        end
        if (cyc != target) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_cyc: reached cycle %0d, required %0d", cyc, target);
        end
    endtask

    // Each run holds pwm_in high for run_h[i] samples then low for run_l[i] samples.
    task automatic drive_runs(input bit sel);
        foreach (run_h[i]) begin
            @(negedge sclk);
            set_pwm(sel, 1'b1);
            rise_cyc.push_back(cyc);
            repeat (run_h[i] - 1) @(negedge sclk);
            @(negedge sclk);
            set_pwm(sel, 1'b0);
            last_fall = cyc;
            repeat (run_l[i] - 1) @(negedge sclk);
        end
    endtask

    // Every rise after the arming one reports the preceding high run and full period.
    function automatic void build_expected(input int maxv);
        exp_q.delete();
        for (int i = 1; i < rise_cyc.size(); i++) begin
            exp_q.push_back('{rise_cyc[i] + LAT,
                              (run_h[i-1] > maxv) ? maxv : run_h[i-1],
                              (run_h[i-1] + run_l[i-1] > maxv) ? maxv : run_h[i-1] + run_l[i-1]});
        end
    endfunction

    task automatic test_reset();
        do_reset();
        checks += 12;
        if (level_a !== 1'b0)    begin failures++; $display("[TB] FAIL reset_level_a: got %b want 0", level_a); end
        if (high_a !== '0)       begin failures++; $display("[TB] FAIL reset_high_a: got %0d want 0", high_a); end
        if (period_a !== '0)     begin failures++; $display("[TB] FAIL reset_period_a: got %0d want 0", period_a); end
        if (valid_a !== 1'b0)    begin failures++; $display("[TB] FAIL reset_valid_a: got %b want 0", valid_a); end
        if (stuck_hi_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_stuck_hi_a: got %b want 0", stuck_hi_a); end
        if (stuck_lo_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_stuck_lo_a: got %b want 0", stuck_lo_a); end
        if (level_b !== 1'b0)    begin failures++; $display("[TB] FAIL reset_level_b: got %b want 0", level_b); end
        if (high_b !== '0)       begin failures++; $display("[TB] FAIL reset_high_b: got %0d want 0", high_b); end
        if (period_b !== '0)     begin failures++; $display("[TB] FAIL reset_period_b: got %0d want 0", period_b); end
        if (valid_b !== 1'b0)    begin failures++; $display("[TB] FAIL reset_valid_b: got %b want 0", valid_b); end
        if (stuck_hi_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_stuck_hi_b: got %b want 0", stuck_hi_b); end
        if (stuck_lo_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_stuck_lo_b: got %b want 0", stuck_lo_b); end
        repeat (50) @(negedge sclk);
        checks += 2;
        if (evq_a.size() !== 0) begin failures++; $display("[TB] FAIL reset_quiet_a: got %0d results want 0", evq_a.size()); end
        if (evq_b.size() !== 0) begin failures++; $display("[TB] FAIL reset_quiet_b: got %0d results want 0", evq_b.size()); end
    endtask

    task automatic test_periodic();
        do_reset();
        repeat (5) begin run_h.push_back(30); run_l.push_back(70); end
        drive_runs(1'b0);
        build_expected(MAX_A);
        checks++;
        if (evq_a.size() !== exp_q.size()) begin
            failures++;
            $display("[TB] FAIL periodic_count: got %0d results want %0d", evq_a.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < evq_a.size()) begin
            checks++;
            if (evq_a[i].cyc !== exp_q[i].cyc || evq_a[i].hi !== exp_q[i].hi || evq_a[i].per !== exp_q[i].per) begin
                failures++;
                $display("[TB] FAIL periodic_result%0d: got cyc=%0d hi=%0d per=%0d want cyc=%0d hi=%0d per=%0d",
                         i, evq_a[i].cyc, evq_a[i].hi, evq_a[i].per, exp_q[i].cyc, exp_q[i].hi, exp_q[i].per);
            end
        end
    endtask

    task automatic test_duty_sweep();
        do_reset();
        run_h = '{1, 99, 1};
        run_l = '{99, 1, 99};
        drive_runs(1'b0);
        build_expected(MAX_A);
        checks++;
        if (evq_a.size() !== exp_q.size()) begin
            failures++;
            $display("[TB] FAIL sweep_count: got %0d results want %0d", evq_a.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < evq_a.size()) begin
            checks++;
            if (evq_a[i].cyc !== exp_q[i].cyc || evq_a[i].hi !== exp_q[i].hi || evq_a[i].per !== exp_q[i].per) begin
                failures++;
                $display("[TB] FAIL sweep_result%0d: got cyc=%0d hi=%0d per=%0d want cyc=%0d hi=%0d per=%0d",
                         i, evq_a[i].cyc, evq_a[i].hi, evq_a[i].per, exp_q[i].cyc, exp_q[i].hi, exp_q[i].per);
            end
        end
        if (evq_a.size() >= 2) begin
            checks++;
            if (evq_a[1].cyc - evq_a[0].cyc !== 100) begin
                failures++;
                $display("[TB] FAIL sweep_spacing: got %0d cycles want 100", evq_a[1].cyc - evq_a[0].cyc);
            end
        end
    endtask

    task automatic test_random_duty();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_h.push_back(int'($urandom_range(150, 1)));
            run_l.push_back(int'($urandom_range(150, 1)));
        end
        drive_runs(1'b0);
        build_expected(MAX_A);
        checks++;
        if (evq_a.size() !== exp_q.size()) begin
            failures++;
            $display("[TB] FAIL random_count: got %0d results want %0d", evq_a.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < evq_a.size()) begin
            checks++;
            if (evq_a[i].cyc !== exp_q[i].cyc || evq_a[i].hi !== exp_q[i].hi || evq_a[i].per !== exp_q[i].per) begin
                failures++;
                $display("[TB] FAIL random_result%0d: got cyc=%0d hi=%0d per=%0d want cyc=%0d hi=%0d per=%0d",
                         i, evq_a[i].cyc, evq_a[i].hi, evq_a[i].per, exp_q[i].cyc, exp_q[i].hi, exp_q[i].per);
            end
        end
    endtask

    task automatic test_stuck_hi();
        int r;
        int f;
        do_reset();
        run_h = '{30};
        run_l = '{70};
        drive_runs(1'b0);
        @(negedge sclk);
        set_pwm(1'b0, 1'b1);
        r = cyc;
        wait_cyc(r + LAT + TIMEOUT_A - 1);
        checks++;
        if (stuck_hi_a !== 1'b0) begin failures++; $display("[TB] FAIL stuck_hi_early: got %b want 0", stuck_hi_a); end
        @(negedge sclk);
        checks += 4;
        if (stuck_hi_a !== 1'b1) begin failures++; $display("[TB] FAIL stuck_hi_set: got %b want 1", stuck_hi_a); end
        if (stuck_lo_a !== 1'b0) begin failures++; $display("[TB] FAIL stuck_hi_lo_flag: got %b want 0", stuck_lo_a); end
        if (high_a !== 30 || period_a !== 100) begin
            failures++;
            $display("[TB] FAIL stuck_hi_held: got hi=%0d per=%0d want hi=30 per=100", high_a, period_a);
        end
        if (evq_a.size() !== 1) begin failures++; $display("[TB] FAIL stuck_hi_count: got %0d results want 1", evq_a.size()); end
        @(negedge sclk);
        set_pwm(1'b0, 1'b0);
        f = cyc;
        wait_cyc(f + LAT - 1);
        checks++;
        if (stuck_hi_a !== 1'b1) begin failures++; $display("[TB] FAIL stuck_hi_hold: got %b want 1", stuck_hi_a); end
        @(negedge sclk);
        checks++;
        if (stuck_hi_a !== 1'b0) begin failures++; $display("[TB] FAIL stuck_hi_clear: got %b want 0", stuck_hi_a); end
        rise_cyc.delete();
        run_h = '{30, 30};
        run_l = '{70, 70};
        drive_runs(1'b0);
        checks++;
        if (evq_a.size() !== 2) begin
            failures++;
            $display("[TB] FAIL rearm_count: got %0d results want 2", evq_a.size());
        end else if (evq_a[1].cyc !== rise_cyc[1] + LAT || evq_a[1].hi !== 30 || evq_a[1].per !== 100) begin
            failures++;
            $display("[TB] FAIL rearm_result: got cyc=%0d hi=%0d per=%0d want cyc=%0d hi=30 per=100",
                     evq_a[1].cyc, evq_a[1].hi, evq_a[1].per, rise_cyc[1] + LAT);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        // 63-cycle runs sit exactly on the timeout boundary, where the edge must win.
        run_h = '{40, 63, 63, 5};
        run_l = '{40, 10, 63, 5};
        drive_runs(1'b1);
        build_expected(MAX_B);
        checks++;
        if (evq_b.size() !== exp_q.size()) begin
            failures++;
            $display("[TB] FAIL sat_count: got %0d results want %0d", evq_b.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < evq_b.size()) begin
            checks++;
            if (evq_b[i].cyc !== exp_q[i].cyc || evq_b[i].hi !== exp_q[i].hi || evq_b[i].per !== exp_q[i].per) begin
                failures++;
                $display("[TB] FAIL sat_result%0d: got cyc=%0d hi=%0d per=%0d want cyc=%0d hi=%0d per=%0d",
                         i, evq_b[i].cyc, evq_b[i].hi, evq_b[i].per, exp_q[i].cyc, exp_q[i].hi, exp_q[i].per);
            end
        end
        wait_cyc(last_fall + LAT + TIMEOUT_B - 1);
        checks++;
        if (stuck_lo_b !== 1'b0) begin failures++; $display("[TB] FAIL stuck_lo_early: got %b want 0", stuck_lo_b); end
        @(negedge sclk);
        checks += 3;
        if (stuck_lo_b !== 1'b1) begin failures++; $display("[TB] FAIL stuck_lo_set: got %b want 1", stuck_lo_b); end
        if (stuck_hi_b !== 1'b0) begin failures++; $display("[TB] FAIL stuck_lo_hi_flag: got %b want 0", stuck_hi_b); end
        if (high_b !== 63 || period_b !== 63) begin
            failures++;
            $display("[TB] FAIL sat_held: got hi=%0d per=%0d want hi=63 per=63", high_b, period_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_h = '{30, 30};
        run_l = '{70, 20};
        drive_runs(1'b0);
        checks++;
        if (evq_a.size() !== 1) begin failures++; $display("[TB] FAIL mid_pre_count: got %0d results want 1", evq_a.size()); end
        do_reset();
        repeat (3) begin run_h.push_back(30); run_l.push_back(70); end
        drive_runs(1'b0);
        build_expected(MAX_A);
        checks++;
        if (evq_a.size() !== exp_q.size()) begin
            failures++;
            $display("[TB] FAIL mid_count: got %0d results want %0d", evq_a.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < evq_a.size()) begin
            checks++;
            if (evq_a[i].cyc !== exp_q[i].cyc || evq_a[i].hi !== exp_q[i].hi || evq_a[i].per !== exp_q[i].per) begin
                failures++;
                $display("[TB] FAIL mid_result%0d: got cyc=%0d hi=%0d per=%0d want cyc=%0d hi=%0d per=%0d",
                         i, evq_a[i].cyc, evq_a[i].hi, evq_a[i].per, exp_q[i].cyc, exp_q[i].hi, exp_q[i].per);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_duty_sweep();
        test_random_duty();
        test_stuck_hi();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
